// File: rtl/store_checker.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// store_checker
//
// Purpose:
//   Sits on the data-memory write port of the multicycle cpu and checks, in
//   order, every store the program issues against a table of expected
//   (address, data) pairs that is loaded before the run starts. The verdict
//   is PASS or FAIL, with the cause, the failing entry, the bus values and
//   pc at failure, and the number of RUN cycles used. Because stores are
//   matched by order rather than by cycle, program tests do not depend on
//   exact instruction timing.
//
// Parameters:
//   DEPTH   - number of expected-store entries (power of two)
//   AW      - log2(DEPTH)
//   TIMEOUT - RUN cycles allowed before a timeout failure
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   synchronous active-high reset, clears all state
//   exp_we     in   expected-table write strobe (LOAD only)
//   exp_addr   in   [31:0] expected store address
//   exp_data   in   [31:0] expected store data
//   start      in   leave LOAD and begin RUN (LOAD only)
//   memwrite   in   cpu store strobe
//   dataaddr   in   [31:0] cpu store address
//   writedata  in   [31:0] cpu store data
//   pc         in   [31:0] cpu pc, captured on failure
//   done       out  verdict reached (PASS or FAIL)
//   pass       out  verdict is PASS
//   fail_code  out  [1:0] 0 none, 1 mismatch, 2 timeout, 3 extra store
//   fail_idx   out  [AW:0] expected-entry index at failure
//   fail_addr  out  [31:0] dataaddr at failure (0 on timeout)
//   fail_data  out  [31:0] writedata at failure (0 on timeout)
//   fail_pc    out  [31:0] pc at failure
//   cycles     out  [31:0] RUN cycle count, saturating
//   state      out  [1:0] 0 LOAD, 1 RUN, 2 PASS, 3 FAIL
//   trace_pc   out  [127:0] last four store pcs, newest in [31:0]
//                   (only when STORE_CHECKER_TRACE_EN is defined)
//
// Build option:
//   `define STORE_CHECKER_TRACE_EN adds a four-entry history of the pc of
//   every store seen during RUN, frozen once the checker fails.
// -----------------------------------------------------------------------------
module store_checker #(
    parameter int DEPTH   = 8,
    parameter int AW      = 3,
    parameter int TIMEOUT = 256
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          exp_we,
    input  logic [31:0]   exp_addr,
    input  logic [31:0]   exp_data,
    input  logic          start,
    input  logic          memwrite,
    input  logic [31:0]   dataaddr,
    input  logic [31:0]   writedata,
    input  logic [31:0]   pc,
    output logic          done,
    output logic          pass,
    output logic [1:0]    fail_code,
    output logic [AW:0]   fail_idx,
    output logic [31:0]   fail_addr,
    output logic [31:0]   fail_data,
    output logic [31:0]   fail_pc,
    output logic [31:0]   cycles,
    output logic [1:0]    state
`ifdef STORE_CHECKER_TRACE_EN
    ,
    output logic [127:0]  trace_pc
`endif
);

    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_RUN  = 2'd1,
        S_PASS = 2'd2,
        S_FAIL = 2'd3
    } state_t;

    localparam logic [AW:0] DEPTH_N      = (AW+1)'(DEPTH);
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT - 1);

    localparam logic [1:0] CODE_NONE     = 2'd0;
    localparam logic [1:0] CODE_MISMATCH = 2'd1;
    localparam logic [1:0] CODE_TIMEOUT  = 2'd2;
    localparam logic [1:0] CODE_EXTRA    = 2'd3;

    // Saturating RUN cycle counter step.
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

    state_t       state_q, state_d;
    logic [AW:0]  n_q;
    logic [AW:0]  rd_ptr_q;
    logic [31:0]  cycles_q;

    // Expected table: contents are don't-care after reset, only n_q matters.
    logic [31:0]  tab_addr [DEPTH];
    logic [31:0]  tab_data [DEPTH];

    logic         table_full;
    logic         load_wr;
    logic [AW:0]  rd_ptr_inc;
    logic         exp_hit;
    logic         last_hit;
    logic         timeout_hit;

    logic         cap_en;
    logic [1:0]   cap_code;
    logic [AW:0]  cap_idx;
    logic [31:0]  cap_addr;
    logic [31:0]  cap_data;

    assign table_full  = (n_q == DEPTH_N);
    assign load_wr     = (state_q == S_LOAD) && exp_we && !table_full;
    assign rd_ptr_inc  = rd_ptr_q + (AW+1)'(1);
    // rd_ptr_q < n_q <= DEPTH while in RUN, so the low AW bits address the table.
    assign exp_hit     = (dataaddr  == tab_addr[rd_ptr_q[AW-1:0]]) &&
                         (writedata == tab_data[rd_ptr_q[AW-1:0]]);
    assign last_hit    = memwrite && exp_hit && (rd_ptr_inc == n_q);
    assign timeout_hit = (cycles_q == TIMEOUT_LAST);

    // Next state and failure capture selection.
    always_comb begin
        state_d  = state_q;
        cap_en   = 1'b0;
        cap_code = CODE_NONE;
        cap_idx  = '0;
        cap_addr = '0;
        cap_data = '0;
        unique case (state_q)
            S_LOAD: begin
                if (start) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (n_q == '0) begin
                    state_d = S_PASS;
                end else if (memwrite && !exp_hit) begin
                    // A mismatch outranks a timeout in the same cycle.
                    state_d  = S_FAIL;
                    cap_en   = 1'b1;
                    cap_code = CODE_MISMATCH;
                    cap_idx  = rd_ptr_q;
                    cap_addr = dataaddr;
                    cap_data = writedata;
                end else if (last_hit) begin
                    // A completing store outranks a timeout in the same cycle.
                    state_d = S_PASS;
                end else if (timeout_hit) begin
                    // A matching store this cycle has already satisfied its
                    // entry, so the outstanding entry is the next one.
                    state_d  = S_FAIL;
                    cap_en   = 1'b1;
                    cap_code = CODE_TIMEOUT;
                    cap_idx  = memwrite ? rd_ptr_inc : rd_ptr_q;
                end
            end
            S_PASS: begin
                if (memwrite) begin
                    state_d  = S_FAIL;
                    cap_en   = 1'b1;
                    cap_code = CODE_EXTRA;
                    cap_idx  = n_q;
                    cap_addr = dataaddr;
                    cap_data = writedata;
                end
            end
            S_FAIL: begin
                state_d = S_FAIL;
            end
            default: begin
                state_d = S_LOAD;
            end
        endcase
    end

    // State, counters and registered verdict outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_LOAD;
            n_q       <= '0;
            rd_ptr_q  <= '0;
            cycles_q  <= '0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail_code <= CODE_NONE;
            fail_idx  <= '0;
            fail_addr <= '0;
            fail_data <= '0;
            fail_pc   <= '0;
        end else begin
            state_q <= state_d;
            done    <= (state_d == S_PASS) || (state_d == S_FAIL);
            pass    <= (state_d == S_PASS);

            if (load_wr) begin
                n_q <= n_q + (AW+1)'(1);
            end

            if (state_q == S_LOAD && start) begin
                cycles_q <= '0;
                rd_ptr_q <= '0;
            end

            if (state_q == S_RUN) begin
                cycles_q <= sat_inc(cycles_q);
                if (memwrite && exp_hit) begin
                    rd_ptr_q <= rd_ptr_inc;
                end
            end

            if (cap_en) begin
                fail_code <= cap_code;
                fail_idx  <= cap_idx;
                fail_addr <= cap_addr;
                fail_data <= cap_data;
                fail_pc   <= pc;
            end
        end
    end

    // Table storage, data only.
    always_ff @(posedge clk) begin
        if (load_wr) begin
            tab_addr[n_q[AW-1:0]] <= exp_addr;
            tab_data[n_q[AW-1:0]] <= exp_data;
        end
    end

    assign cycles = cycles_q;
    assign state  = state_q;

`ifdef STORE_CHECKER_TRACE_EN
    // Shift-in history of store pcs; only RUN updates it, so it stays frozen
    // in PASS and FAIL.
    always_ff @(posedge clk) begin
        if (reset) begin
            trace_pc <= '0;
        end else if (state_q == S_RUN && memwrite) begin
            trace_pc <= {trace_pc[95:0], pc};
        end
    end
`endif

endmodule

// File: tb/tb_store_checker.sv
`timescale 1ns/1ps
module tb_store_checker;

    localparam int DEPTH   = 8;
    localparam int AW      = 3;
    localparam int TIMEOUT = 20;
    localparam int NRUN    = TIMEOUT + 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          exp_we = 1'b0;
    logic [31:0]   exp_addr = '0;
    logic [31:0]   exp_data = '0;
    logic          start = 1'b0;
    logic          memwrite = 1'b0;
    logic [31:0]   dataaddr = '0;
    logic [31:0]   writedata = '0;
    logic [31:0]   pc = '0;
    logic          done;
    logic          pass;
    logic [1:0]    fail_code;
    logic [AW:0]   fail_idx;
    logic [31:0]   fail_addr;
    logic [31:0]   fail_data;
    logic [31:0]   fail_pc;
    logic [31:0]   cycles;
    logic [1:0]    state;
`ifdef STORE_CHECKER_TRACE_EN
    logic [127:0]  trace_pc;
`endif

    always #5 clk = ~clk;

    store_checker #(.DEPTH(DEPTH), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .exp_we(exp_we), .exp_addr(exp_addr),
        .exp_data(exp_data), .start(start), .memwrite(memwrite),
        .dataaddr(dataaddr), .writedata(writedata), .pc(pc),
        .done(done), .pass(pass), .fail_code(fail_code), .fail_idx(fail_idx),
        .fail_addr(fail_addr), .fail_data(fail_data), .fail_pc(fail_pc),
        .cycles(cycles), .state(state)
`ifdef STORE_CHECKER_TRACE_EN
        , .trace_pc(trace_pc)
`endif
    );

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [1:0]  st;
        logic [1:0]  code;
        logic [AW:0] idx;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] p;
        logic [31:0] cyc;
    } exp_t;

    exp_t expq[$];
    exp_t mon_e;

    // Expected table as loaded (up to one more than DEPTH) and the RUN plan.
    logic [31:0] tab_a [10];
    logic [31:0] tab_d [10];
    int          nload;
    bit          p_we [NRUN];
    logic [31:0] p_a  [NRUN];
    logic [31:0] p_d  [NRUN];
    logic [31:0] p_pc [NRUN];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic push(input logic [1:0] st, input logic [1:0] code, input int idx,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] p, input int cyc);
        exp_t e;
        e.st = st; e.code = code; e.idx = idx[AW:0];
        e.a = a; e.d = d; e.p = p; e.cyc = 32'(cyc);
        expq.push_back(e);
    endtask

    // Reference: walk the RUN cycles in order and apply the checking rules
    // directly to the loaded list and the planned stores.
    task automatic model(input int limit);
        int  n;
        int  k;
        bit  passed;
        int  pcyc;
        n = (nload > DEPTH) ? DEPTH : nload;
        k = 0;
        passed = 0;
        pcyc = 0;
        for (int c = 0; c < limit; c++) begin
            if (!passed) begin
                if (n == 0) begin
                    passed = 1; pcyc = c + 1;
                    push(2'd2, 2'd0, 0, 0, 0, 0, pcyc);
                    continue;
                end
                if (p_we[c]) begin
                    if (p_a[c] == tab_a[k] && p_d[c] == tab_d[k]) begin
                        k++;
                        if (k == n) begin
                            passed = 1; pcyc = c + 1;
                            push(2'd2, 2'd0, 0, 0, 0, 0, pcyc);
                            continue;
                        end
                    end else begin
                        push(2'd3, 2'd1, k, p_a[c], p_d[c], p_pc[c], c + 1);
                        return;
                    end
                end
                if (c == TIMEOUT - 1) begin
                    push(2'd3, 2'd2, k, 0, 0, p_pc[c], c + 1);
                    return;
                end
            end else if (p_we[c]) begin
                push(2'd3, 2'd3, n, p_a[c], p_d[c], p_pc[c], pcyc);
                return;
            end
        end
    endtask

    // Monitor: every entry into PASS or FAIL is one DUT response.
    logic [1:0] prev_state = 2'd0;
    always @(negedge clk) begin
        if (state !== prev_state && state[1] === 1'b1) begin
            if (expq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_verdict actual_state=%0d expected=none at %0t", state, $time);
            end else begin
                mon_e = expq.pop_front();
                chk("state", 32'(state), 32'(mon_e.st));
                chk("done", 32'(done), 32'd1);
                chk("pass", 32'(pass), 32'(mon_e.st == 2'd2));
                chk("fail_code", 32'(fail_code), 32'(mon_e.code));
                chk("fail_idx", 32'(fail_idx), 32'(mon_e.idx));
                chk("fail_addr", fail_addr, mon_e.a);
                chk("fail_data", fail_data, mon_e.d);
                chk("fail_pc", fail_pc, mon_e.p);
                chk("cycles", cycles, mon_e.cyc);
            end
        end
        prev_state = state;
    end

    task automatic clear_plan();
        for (int c = 0; c < NRUN; c++) begin
            p_we[c] = 0; p_a[c] = $urandom; p_d[c] = $urandom; p_pc[c] = $urandom;
        end
    endtask

    task automatic set_store(input int c, input logic [31:0] a, input logic [31:0] d,
                             input logic [31:0] p);
        p_we[c] = 1; p_a[c] = a; p_d[c] = d; p_pc[c] = p;
    endtask

    task automatic do_reset();
        reset = 1; exp_we = 0; start = 0; memwrite = 0;
        @(posedge clk); #1;
        reset = 0;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_pass", 32'(pass), 32'd0);
        chk("rst_fail_code", 32'(fail_code), 32'd0);
        chk("rst_fail_idx", 32'(fail_idx), 32'd0);
        chk("rst_fail_addr", fail_addr, 32'd0);
        chk("rst_fail_data", fail_data, 32'd0);
        chk("rst_fail_pc", fail_pc, 32'd0);
        chk("rst_cycles", cycles, 32'd0);
    endtask

    task automatic load_and_start(input bit merge);
        for (int i = 0; i < nload; i++) begin
            exp_we = 1; exp_addr = tab_a[i]; exp_data = tab_d[i];
            memwrite = 1'($urandom_range(0, 1));
            dataaddr = $urandom; writedata = $urandom; pc = $urandom;
            start = merge && (i == nload - 1);
            @(posedge clk); #1;
        end
        if (!(merge && nload > 0)) begin
            exp_we = 0; memwrite = 0; start = 1;
            @(posedge clk); #1;
        end
        exp_we = 0; start = 0; memwrite = 0;
    endtask

    task automatic drive_run(input int limit);
        for (int c = 0; c < limit; c++) begin
            memwrite = p_we[c]; dataaddr = p_a[c]; writedata = p_d[c]; pc = p_pc[c];
            exp_we = ($urandom_range(0, 3) == 0); exp_addr = $urandom; exp_data = $urandom;
            start = ($urandom_range(0, 3) == 0);
            @(posedge clk); #1;
        end
        memwrite = 0; exp_we = 0; start = 0;
    endtask

    task automatic run_scenario(input bit merge, input int reset_at);
        int limit;
        do_reset();
        load_and_start(merge);
        limit = (reset_at >= 0) ? reset_at : NRUN;
        model(limit);
        drive_run(limit);
        if (reset_at >= 0) do_reset();
        else begin
            @(posedge clk); #1;
        end
        repeat (2) @(negedge clk);
        chk("pending_responses", 32'(expq.size()), 32'd0);
        expq.delete();
    endtask

    task automatic gen_random();
        int neff;
        int m;
        int c;
        nload = $urandom_range(0, 9);
        for (int i = 0; i < 10; i++) begin
            tab_a[i] = $urandom; tab_d[i] = $urandom;
        end
        clear_plan();
        neff = (nload > DEPTH) ? DEPTH : nload;
        m = neff + $urandom_range(0, 1);
        c = $urandom_range(1, 3);
        for (int i = 0; i < m; i++) begin
            if (c >= NRUN) break;
            if (i < neff) begin
                set_store(c, tab_a[i], tab_d[i], $urandom);
                if ($urandom_range(0, 9) == 0) begin
                    if ($urandom_range(0, 1) == 1) p_a[c] = p_a[c] ^ (32'h1 << $urandom_range(0, 31));
                    else                           p_d[c] = p_d[c] ^ (32'h1 << $urandom_range(0, 31));
                end
            end else begin
                set_store(c, $urandom, $urandom, $urandom);
            end
            c += 1 + $urandom_range(0, 2);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        // Single matching store late in the run.
        nload = 1; tab_a[0] = 6; tab_d[0] = 6;
        clear_plan(); set_store(18, 6, 6, 32'h40);
        run_scenario(0, -1);

        // Data mismatch.
        nload = 1; tab_a[0] = 6; tab_d[0] = 6;
        clear_plan(); set_store(3, 6, 11, 32'h10);
        run_scenario(1, -1);

        // Timeout after one of two stores.
        nload = 2; tab_a[0] = 32'h100; tab_d[0] = 1; tab_a[1] = 32'h104; tab_d[1] = 2;
        clear_plan(); set_store(5, 32'h100, 1, 32'h20);
        run_scenario(0, -1);

        // Extra store after PASS.
        nload = 1; tab_a[0] = 4; tab_d[0] = 9;
        clear_plan(); set_store(2, 4, 9, 32'h30); set_store(6, 8, 1, 32'h34);
        run_scenario(0, -1);

        // Nine loads into eight entries; the ninth store is an extra.
        nload = 9;
        for (int i = 0; i < 10; i++) begin tab_a[i] = 32'h1000 + 4 * i; tab_d[i] = 32'hA0 + i; end
        clear_plan();
        for (int i = 0; i < 9; i++) set_store(1 + 2 * i, tab_a[i], tab_d[i], 32'h200 + i);
        run_scenario(0, -1);

        // Empty table.
        nload = 0; clear_plan();
        run_scenario(0, -1);

        // Completing store on the timeout cycle, then a mismatch on it.
        nload = 1; tab_a[0] = 32'h55; tab_d[0] = 32'h66;
        clear_plan(); set_store(TIMEOUT - 1, 32'h55, 32'h66, 32'h70);
        run_scenario(0, -1);
        clear_plan(); set_store(TIMEOUT - 1, 32'h55, 32'h67, 32'h74);
        run_scenario(0, -1);

        // Matching but non-completing store on the timeout cycle.
        nload = 2; tab_a[0] = 1; tab_d[0] = 2; tab_a[1] = 3; tab_d[1] = 4;
        clear_plan(); set_store(TIMEOUT - 1, 1, 2, 32'h78);
        run_scenario(1, -1);

        // Reset mid-RUN after one of three stores, then a normal single-entry pass.
        nload = 3;
        for (int i = 0; i < 3; i++) begin tab_a[i] = 32'h300 + i; tab_d[i] = i; end
        clear_plan(); set_store(2, 32'h300, 0, 32'h80);
        run_scenario(0, 6);
        nload = 1; tab_a[0] = 32'hDEAD; tab_d[0] = 32'hBEEF;
        clear_plan(); set_store(4, 32'hDEAD, 32'hBEEF, 32'h84);
        run_scenario(0, -1);

        // Randomized runs.
        for (int t = 0; t < 60; t++) begin
            gen_random();
            run_scenario(1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 15)) : -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
